// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/bubble controller for the 5-stage pipeline.
//
// The instruction in D may advance only when every operand it reads will be
// ready by the time it needs it. Readiness uses Tuse/Tnew timing against the
// producers in E and M. The block also owns the multiply/divide busy
// sequencer. Any HI/LO user in D waits until that sequencer has finished.
// A stall freezes F and D and clears the E register, which injects a bubble.
// Stalled cycles are counted for the performance log.
//
// Parameters
//   MULT_CYCLES  busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES   busy cycles after a div/divu start   (1..15)
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous reset, active-low
//   D_rs/D_rt    source register fields of the instruction in D
//   D_rs_tuse    cycles until D needs rs (3 = rs not read)
//   D_rt_tuse    cycles until D needs rt (3 = rt not read)
//   D_md_use     D holds mult/div/mfhi/mflo/mthi/mtlo
//   E_a3/E_tnew  destination and result latency of the instruction in E
//   M_a3/M_tnew  destination and result latency of the instruction in M
//   E_md_start   E holds mult/multu/div/divu this cycle
//   E_md_is_div  qualifies E_md_start: 1 = div, 0 = mult
//   stall        D must hold this cycle (combinational)
//   F_en, D_en   PC/F and D register enables (= ~stall)
//   E_clr        E register clear, the bubble (= stall)
//   E_en         E register enable (always 1)
//   md_busy      multiply/divide unit busy
//   md_done      one-cycle pulse in the last busy cycle
//   stall_cnt    saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_md_use,
  input  logic [4:0]  E_a3,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_a3,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        stall,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        E_en,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  // The counter holds "busy cycles remaining minus one". A start therefore
  // gives exactly N BUSY cycles, and the last one is the cycle where cnt == 0.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t   state;
  md_state_t   state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [31:0] stall_cnt_q;

  logic rs_hazard;
  logic rt_hazard;
  logic reg_hazard;
  logic md_hazard;

  // A source conflicts with a producer when both name the same non-zero
  // register and the result arrives later than the consumer needs it.
  // A tuse of 3 means the operand is not read at all.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (src == dst) && (tuse != TUSE_NONE) && (tnew > tuse);
  endfunction

  // Saturating increment for the performance counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection (purely combinational, same-cycle decision)
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_hazard  = src_hazard(D_rs, D_rs_tuse, E_a3, E_tnew) |
                 src_hazard(D_rs, D_rs_tuse, M_a3, M_tnew);
    rt_hazard  = src_hazard(D_rt, D_rt_tuse, E_a3, E_tnew) |
                 src_hazard(D_rt, D_rt_tuse, M_a3, M_tnew);
    reg_hazard = rs_hazard | rt_hazard;
    md_hazard  = D_md_use & md_busy;
  end

  always_comb begin
    stall = reg_hazard | md_hazard;
    F_en  = ~stall;
    D_en  = ~stall;
    // The E register stays enabled, so the clear loads a bubble.
    E_clr = stall;
    E_en  = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (E_md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = E_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        // A new start always wins. This covers both a restart mid-operation
        // and a back-to-back start in the final cycle.
        if (E_md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = E_md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt == 4'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer: outputs
  // ---------------------------------------------------------------------------
  // md_busy includes the start cycle itself. This lets an mfhi that directly
  // follows the mult/div stall in the same cycle that the operation enters E.
  always_comb begin
    md_busy = E_md_start | (state == BUSY);
    md_done = (state == BUSY) && (cnt == 4'd0);
  end

  // ---------------------------------------------------------------------------
  // Stall performance counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_md_use;
  logic [4:0]  E_a3;
  logic [1:0]  E_tnew;
  logic [4:0]  M_a3;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_is_div;
  logic        stall;
  logic        F_en;
  logic        D_en;
  logic        E_clr;
  logic        E_en;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_tuse  (D_rs_tuse),
    .D_rt_tuse  (D_rt_tuse),
    .D_md_use   (D_md_use),
    .E_a3       (E_a3),
    .E_tnew     (E_tnew),
    .M_a3       (M_a3),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_is_div(E_md_is_div),
    .stall      (stall),
    .F_en       (F_en),
    .D_en       (D_en),
    .E_clr      (E_clr),
    .E_en       (E_en),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       md_use;
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] outs;
  } exp_t;

  localparam int NVEC = 13;
  vec_t  vecs [NVEC];
  exp_t  sb [$];
  int    total = 0;
  int    bad   = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [1:0] rs_tuse,
    input logic [4:0] rt, input logic [1:0] rt_tuse,
    input logic md_use,
    input logic [4:0] e_a3, input logic [1:0] e_tnew,
    input logic [4:0] m_a3, input logic [1:0] m_tnew,
    input logic exp_stall
  );
    vec_t v;
    v.rs = rs; v.rs_tuse = rs_tuse; v.rt = rt; v.rt_tuse = rt_tuse;
    v.md_use = md_use; v.e_a3 = e_a3; v.e_tnew = e_tnew;
    v.m_a3 = m_a3; v.m_tnew = m_tnew; v.exp_stall = exp_stall;
    return v;
  endfunction

  // Output order: {stall, F_en, D_en, E_clr, E_en, md_busy, md_done}
  function automatic logic [6:0] pack_exp(input logic s, input logic b, input logic d);
    return {s, ~s, ~s, s, 1'b1, b, d};
  endfunction

  task automatic push_exp(input string name, input logic s, input logic b, input logic d);
    exp_t e;
    e.name = name;
    e.outs = pack_exp(s, b, d);
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [6:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {stall, F_en, D_en, E_clr, E_en, md_busy, md_done};
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL %s: outs got %b want %b (stall,F_en,D_en,E_clr,E_en,md_busy,md_done)",
                 e.name, act, e.outs);
      end
    end
    total++;
    if (stall_cnt !== model_cnt) begin
      bad++;
      $display("FAIL stall_cnt: got %h want %h", stall_cnt, model_cnt);
    end
  endtask

  // One pipeline cycle: expectation queued with the stimulus, compared at the
  // falling edge, model counter advanced for the coming rising edge.
  task automatic cyc(input string name, input logic s, input logic b, input logic d);
    push_exp(name, s, b, d);
    @(negedge clk);
    check_now();
    if (s && reset && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    D_md_use = 1'b0; E_a3 = 5'd0; E_tnew = 2'd0; M_a3 = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    D_rs = v.rs; D_rt = v.rt; D_rs_tuse = v.rs_tuse; D_rt_tuse = v.rt_tuse;
    D_md_use = v.md_use; E_a3 = v.e_a3; E_tnew = v.e_tnew;
    M_a3 = v.m_a3; M_tnew = v.m_tnew;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  initial begin
    //           rs tuse rt tuse md  E_a3 tn M_a3 tn stall
    vecs[0]  = mk(1, 1,  0, 3,   0,  1,   2, 0,   0, 1); // lw $1 in E, addu uses $1
    vecs[1]  = mk(1, 1,  0, 3,   0,  0,   0, 1,   1, 0); // next cycle: lw in M, bubble in E
    vecs[2]  = mk(0, 0,  0, 3,   0,  0,   2, 0,   0, 0); // $0 never conflicts
    vecs[3]  = mk(5, 3,  0, 3,   0,  5,   2, 0,   0, 0); // tuse 3 never stalls
    vecs[4]  = mk(0, 3,  7, 0,   0,  7,   1, 0,   0, 1); // rt vs E
    vecs[5]  = mk(0, 3,  7, 1,   0,  7,   1, 0,   0, 0); // tnew == tuse is fine
    vecs[6]  = mk(9, 0,  0, 3,   0,  0,   0, 9,   1, 1); // rs vs M
    vecs[7]  = mk(0, 3,  9, 0,   0,  0,   0, 9,   1, 1); // rt vs M
    vecs[8]  = mk(3, 0,  0, 3,   0,  4,   2, 0,   0, 0); // different register
    vecs[9]  = mk(0, 3, 31, 1,   0, 31,   2, 0,   0, 1); // rt=31, tnew 2 > tuse 1
    vecs[10] = mk(0, 3, 12, 3,   0,  0,   0, 12,  1, 0); // rt not read
    vecs[11] = mk(0, 3,  0, 3,   1,  0,   0, 0,   0, 0); // HI/LO user, unit idle
    vecs[12] = mk(2, 0,  0, 3,   0,  2,   0, 0,   0, 0); // producer ready now

    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    push_exp("reset_outs", 1'b0, 1'b0, 1'b0);
    check_now();
    E_md_start = 1'b1;
    #1;
    push_exp("reset_busy_follows_start", 1'b0, 1'b1, 1'b0);
    check_now();
    E_md_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Register hazard table
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i]);
      cyc($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0, 1'b0);
    end

    // mult followed by a dependent mfhi
    idle_inputs();
    D_md_use = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      E_md_start  = (i == 0);
      E_md_is_div = 1'b0;
      cyc($sformatf("mult_mfhi_c%0d", i), (i < 6), (i < 6), (i == 5));
    end

    // div with a back-to-back div in the done cycle
    idle_inputs();
    for (int i = 0; i <= 21; i++) begin
      E_md_start  = (i == 0) || (i == 10);
      E_md_is_div = 1'b1;
      cyc($sformatf("div_b2b_c%0d", i), 1'b0, (i <= 20), (i == 10) || (i == 20));
    end

    // Reset in the middle of a divide, when cnt == 3
    idle_inputs();
    D_md_use = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      E_md_start  = (i == 0);
      E_md_is_div = 1'b1;
      cyc($sformatf("div_pre_rst_c%0d", i), 1'b1, 1'b1, 1'b0);
    end
    E_md_start = 1'b0;
    #1 reset = 1'b0;
    model_cnt = 32'd0;
    #1;
    push_exp("rst_abort_now", 1'b0, 1'b0, 1'b0);
    check_now();
    @(negedge clk);
    push_exp("rst_abort_held", 1'b0, 1'b0, 1'b0);
    check_now();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("post_rst_c%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Counter saturation
    idle_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    model_cnt = 32'hFFFF_FFFE;
    apply_vec(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("sat_c%0d", i), 1'b1, 1'b0, 1'b0);
    end
    idle_inputs();
    cyc("sat_hold", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
